// File: rtl/store_buffer.sv
// Data-side store buffer: queues stores, retires them in idle port cycles, serves loads directly.
// Optional macro SB_FORWARD_EN: forward load data from the youngest matching entry instead of stalling.
module store_buffer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic                  ld_valid,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  sb_empty,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [PTR_W:0]        r_count;

    logic w_load_req;
    logic w_store_req;
    logic w_match;
    logic w_load_stall;
    logic w_store_stall;
    logic w_load_acc;
    logic w_drain;
    logic w_enq;
`ifdef SB_FORWARD_EN
    logic [DATA_WIDTH-1:0] w_fwd_data;
`endif

    assign w_load_req  = req_valid & ~req_we;
    assign w_store_req = req_valid & req_we;

    // Scan oldest to youngest so the last hit is the youngest matching entry.
    always_comb begin
        w_match = 1'b0;
`ifdef SB_FORWARD_EN
        w_fwd_data = '0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((PTR_W + 1)'(i) < r_count) &&
                (r_addr[r_head + PTR_W'(i)] == req_addr)) begin
                w_match = 1'b1;
`ifdef SB_FORWARD_EN
                w_fwd_data = r_data[r_head + PTR_W'(i)];
`endif
            end
        end
    end

`ifdef SB_FORWARD_EN
    assign w_load_stall = 1'b0;
`else
    assign w_load_stall = w_load_req & w_match;
`endif

    assign w_load_acc    = w_load_req & ~w_load_stall & ~reset;
    assign w_drain       = (r_count != '0) & ~w_load_acc & ~reset;
    assign w_store_stall = w_store_req & (r_count == FULL_CNT) & ~w_drain;
    assign w_enq         = w_store_req & ~w_store_stall & ~reset;

    assign stall     = ~reset & (w_load_stall | w_store_stall);
    assign mem_we    = w_drain;
    assign mem_addr  = w_drain ? r_addr[r_head] : req_addr;
    assign mem_wdata = r_data[r_head];
    assign sb_empty  = (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            ld_valid <= 1'b0;
            ld_data  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_addr[r_tail] <= req_addr;
                r_data[r_tail] <= req_wdata;
                r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            ld_valid <= w_load_acc;
            if (w_load_acc) begin
`ifdef SB_FORWARD_EN
                ld_data <= w_match ? w_fwd_data : mem_rdata;
`else
                ld_data <= mem_rdata;
`endif
            end
        end
    end

endmodule
